// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg -- shared DES constants and permutation tables.
//
// Contents:
//   KEY_W / SUBKEY_W / CD_W / PC1_W : key, subkey, half-register, PC1 widths
//   PC1, PC2, SHIFT                 : standard DES tables, 1-based bit numbers
//                                     where bit 1 is the MSB of the vector
//   pc1(), rotl28(), rotr28()       : helpers shared by the key schedule
//   shift_sum()                     : total left rotation after N rounds (mod 28)
//   state_t                         : key schedule FSM states
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 28;
  localparam int PC1_W    = 2 * CD_W;

  // Permuted choice 1: 64-bit key -> 56-bit C||D (parity bits dropped).
  localparam int PC1 [PC1_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: 56-bit C||D -> 48-bit subkey.
  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount for rounds 1..16 (index 0 = round 1).
  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [PC1_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [PC1_W-1:0] r;
    r = '0;
    for (int i = 0; i < PC1_W; i++) begin
      r[PC1_W-1-i] = k[KEY_W-PC1[i]];
    end
    return r;
  endfunction

  // n must be 0..27; n = 0 leaves x unchanged because x >> 28 is zero.
  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input int n);
    return (x << n) | (x >> (CD_W - n));
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input int n);
    return (x >> n) | (x << (CD_W - n));
  endfunction

  // Rotation that takes PC1 halves straight to the state of the last round.
  // For the full 16 rounds this is 28, i.e. no rotation at all.
  function automatic int shift_sum(input int rounds);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < rounds) s = s + SHIFT[i];
    end
    return s % CD_W;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// -----------------------------------------------------------------------------
// des_key_schedule_if -- key load and subkey stream bus of the key schedule.
//
// Signals:
//   key[63:0], key_valid, key_ready, decrypt : key load handshake
//   abort                                    : drop the schedule in progress
//   subkey[47:0], subkey_valid, subkey_ready : subkey stream handshake
//   subkey_idx[IDX_W-1:0], subkey_last       : round-1 and end-of-schedule flag
// Modports:
//   master : key source / subkey consumer
//   slave  : the key schedule itself
// -----------------------------------------------------------------------------
interface des_key_schedule_if #(
  parameter int IDX_W = 4
);
  import des_pkg::*;

  logic [KEY_W-1:0]    key;
  logic                key_valid;
  logic                key_ready;
  logic                decrypt;
  logic                abort;
  logic [SUBKEY_W-1:0] subkey;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [IDX_W-1:0]    subkey_idx;
  logic                subkey_last;

  modport master (
    output key, key_valid, decrypt, abort, subkey_ready,
    input  key_ready, subkey, subkey_valid, subkey_idx, subkey_last
  );

  modport slave (
    input  key, key_valid, decrypt, abort, subkey_ready,
    output key_ready, subkey, subkey_valid, subkey_idx, subkey_last
  );

endinterface

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2 -- DES permuted choice 2, purely combinational.
//
// Ports:
//   cd     [55:0] in  : C||D, DES bit 1 = cd[55]
//   subkey [47:0] out : round subkey, DES bit 1 = subkey[47]
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [PC1_W-1:0]    cd,
  output logic [SUBKEY_W-1:0] subkey
);

  // PC2 discards eight of the 56 C||D bits; fold them all into a sink.
  logic unused_cd;
  assign unused_cd = ^cd;

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[SUBKEY_W-1-i] = cd[PC1_W-PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule -- streams the DES round subkeys for one key.
//
// A key is accepted on key_valid && key_ready (only in IDLE). The subkeys are
// then offered one per cycle on the subkey handshake, K1..KROUNDS for encrypt
// or KROUNDS..K1 for decrypt, with subkey_idx = round-1 and subkey_last on the
// final one. abort drops the schedule from RUN.
//
// Parameters:
//   ROUNDS : subkeys per key, 1..16
//   IDX_W  : width of subkey_idx, must hold ROUNDS-1
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low
//   bus        : des_key_schedule_if.slave
//   parity_err : only with DES_KEY_PARITY_CHK_EN defined; set on a key
//                transfer when any key byte has even parity
// -----------------------------------------------------------------------------
module des_key_schedule
  import des_pkg::*;
#(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  des_key_schedule_if.slave bus
`ifdef DES_KEY_PARITY_CHK_EN
  ,
  output logic              parity_err
`endif
);

  // Loading straight into the last-round state lets decrypt walk backwards
  // with plain right rotations.
  localparam int DEC_LOAD_ROT = shift_sum(ROUNDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);

  state_t              state_q, state_n;
  logic                rdy_en_q;
  logic [CD_W-1:0]     c_q, d_q;
  logic [IDX_W-1:0]    idx_q;
  logic                dec_q;
  logic                key_ready_w, sub_valid_w, last_w;
  logic                key_xfer, sub_hs;
  logic [PC1_W-1:0]    pc1_w;
  logic [SUBKEY_W-1:0] subkey_w;
  int                  rot_ld, rot_enc, rot_dec;

  // Parity bits of the key are not part of the schedule.
  logic unused_key;
  assign unused_key = ^bus.key;

  assign key_xfer = bus.key_valid && key_ready_w;
  assign sub_hs   = sub_valid_w && bus.subkey_ready;
  assign pc1_w    = pc1(bus.key);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // FSM next state; abort wins over a simultaneous last handshake
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (key_xfer) state_n = S_RUN;
      S_RUN:  if (bus.abort || (sub_hs && last_w)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs; rdy_en_q keeps key_ready low while reset is held
  always_comb begin
    key_ready_w = (state_q == S_IDLE) && rdy_en_q;
    sub_valid_w = (state_q == S_RUN);
    last_w      = sub_valid_w && (dec_q ? (idx_q == '0) : (idx_q == IDX_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  // Rotation for the next step: encrypt moves to round r+1 (SHIFT[r+1]),
  // decrypt undoes round r (SHIFT[r]), with r = idx_q + 1.
  always_comb begin
    rot_enc = 0;
    rot_dec = 0;
    if (int'(idx_q) + 1 < 16) rot_enc = SHIFT[int'(idx_q) + 1];
    if (int'(idx_q) < 16)     rot_dec = SHIFT[int'(idx_q)];
    rot_ld = bus.decrypt ? DEC_LOAD_ROT : SHIFT[0];
  end

  // C/D and round index; frozen whenever no handshake happens
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q   <= '0;
      d_q   <= '0;
      idx_q <= '0;
      dec_q <= 1'b0;
    end else if (key_xfer) begin
      c_q   <= rotl28(pc1_w[PC1_W-1:CD_W], rot_ld);
      d_q   <= rotl28(pc1_w[CD_W-1:0], rot_ld);
      dec_q <= bus.decrypt;
      idx_q <= bus.decrypt ? IDX_LAST : '0;
    end else if (sub_hs && !last_w) begin
      if (dec_q) begin
        c_q   <= rotr28(c_q, rot_dec);
        d_q   <= rotr28(d_q, rot_dec);
        idx_q <= idx_q - 1'b1;
      end else begin
        c_q   <= rotl28(c_q, rot_enc);
        d_q   <= rotl28(d_q, rot_enc);
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey_w)
  );

  assign bus.key_ready    = key_ready_w;
  assign bus.subkey       = subkey_w;
  assign bus.subkey_valid = sub_valid_w;
  assign bus.subkey_idx   = idx_q;
  assign bus.subkey_last  = last_w;

`ifdef DES_KEY_PARITY_CHK_EN
  // Each DES key byte should carry odd parity.
  function automatic logic key_parity_bad(input logic [KEY_W-1:0] k);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < KEY_W / 8; i++) begin
      bad = bad | ~(^k[8*i +: 8]);
    end
    return bad;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        parity_err <= 1'b0;
    else if (key_xfer) parity_err <= key_parity_bad(bus.key);
  end
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule -- self-checking bench for des_key_schedule.
// Reference schedule: each subkey is derived directly from PC1 bits
// rotated by the cumulative shift of its round, then PC2.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

  localparam int ROUNDS = 16;
  localparam int IDX_W  = 4;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  des_key_schedule_if #(.IDX_W(IDX_W)) bus ();

`ifdef DES_KEY_PARITY_CHK_EN
  logic parity_err;
`endif

  des_key_schedule #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [47:0] model_k [16];
  logic [47:0] obs_k   [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Subkey r = PC2 of (PC1 halves rotated left by the sum of shifts 1..r).
  task automatic build_model(input logic [63:0] k);
    logic        c0 [28];
    logic        d0 [28];
    logic [56:1] cd;
    logic [47:0] sk;
    int          cum;
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64 - T_PC1[i]];
      d0[i] = k[64 - T_PC1[28 + i]];
    end
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum = (cum + T_SHIFT[r]) % 28;
      for (int i = 0; i < 28; i++) begin
        cd[i + 1]  = c0[(i + cum) % 28];
        cd[i + 29] = d0[(i + cum) % 28];
      end
      for (int j = 1; j <= 48; j++) sk[48 - j] = cd[T_PC2[j - 1]];
      model_k[r] = sk;
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles at idx 4.
  // stop_at >= 0 returns with the DUT presenting that position, unconsumed.
  task automatic run_sched(input logic [63:0] k, input logic dec, input int mode,
                           input int stop_at);
    int          e, cyc, stall, to, exp_idx;
    logic        rdy, prev_rdy;
    logic [47:0] prev_sk;
    logic [3:0]  prev_idx;
    build_model(k);
    to = 0;
    while (!bus.key_ready && to < 50) begin
      tick();
      to++;
    end
    check("key_ready_before_load", bus.key_ready, 1'b1);
    bus.key       = k;
    bus.decrypt   = dec;
    bus.key_valid = 1'b1;
    tick();
    // Scramble the key inputs so a spurious reload would show up.
    bus.key_valid = 1'b0;
    bus.key       = {$urandom, $urandom};
    bus.decrypt   = ~dec;
    e = 0; cyc = 0; stall = 0; prev_rdy = 1'b1;
    prev_sk = '0; prev_idx = '0;
    while (e < ROUNDS && cyc < 400 && e != stop_at) begin
      exp_idx = dec ? (ROUNDS - 1 - e) : e;
      case (mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(e == 4 && stall < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall++;
      bus.subkey_ready = rdy;
      check("subkey_valid", bus.subkey_valid, 1'b1);
      check("subkey", bus.subkey, model_k[exp_idx]);
      check("subkey_idx", bus.subkey_idx, exp_idx);
      check("subkey_last", bus.subkey_last, (e == ROUNDS - 1));
      check("key_ready_in_run", bus.key_ready, 1'b0);
      if (!prev_rdy) begin
        check("hold_subkey", bus.subkey, prev_sk);
        check("hold_idx", bus.subkey_idx, prev_idx);
      end
      obs_k[e] = bus.subkey;
      prev_rdy = rdy; prev_sk = bus.subkey; prev_idx = bus.subkey_idx;
      if (rdy) e++;
      tick();
      cyc++;
    end
    check("schedule_bound", (cyc < 400), 1'b1);
    if (stop_at < 0) begin
      if (mode == 0) check("one_per_cycle", cyc, ROUNDS);
      check("idle_valid_after_last", bus.subkey_valid, 1'b0);
      check("idle_key_ready_after_last", bus.key_ready, 1'b1);
    end
  endtask

  initial begin
    bus.key = '0; bus.key_valid = 1'b0; bus.decrypt = 1'b0;
    bus.abort = 1'b0; bus.subkey_ready = 1'b0;
    reset = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", bus.subkey_valid, 1'b0);
    check("rst_last", bus.subkey_last, 1'b0);
    check("rst_idx", bus.subkey_idx, 0);
    check("rst_key_ready", bus.key_ready, 1'b0);
    check("rst_subkey", bus.subkey, 0);
    reset = 1'b1;
    tick();
    check("post_rst_key_ready", bus.key_ready, 1'b1);
    check("post_rst_valid", bus.subkey_valid, 1'b0);

    // abort in IDLE has no effect
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_key_ready", bus.key_ready, 1'b1);
    check("idle_abort_valid", bus.subkey_valid, 1'b0);

    // Encrypt known answer
    run_sched(KAT_KEY, 1'b0, 0, -1);
    check("enc_K1", obs_k[0], 48'h1B02EFFC7072);
    check("enc_K2", obs_k[1], 48'h79AED9DBC9E5);
    check("enc_K16", obs_k[15], 48'hCB3D8B0E17F5);
`ifdef DES_KEY_PARITY_CHK_EN
    check("parity_clean", parity_err, 1'b0);
`endif

    // Decrypt known answer
    run_sched(KAT_KEY, 1'b1, 0, -1);
    check("dec_first", obs_k[0], 48'hCB3D8B0E17F5);
    check("dec_last", obs_k[15], 48'h1B02EFFC7072);

    // Backpressure at idx 4
    run_sched(KAT_KEY, 1'b0, 2, -1);
    check("bp_K1", obs_k[0], 48'h1B02EFFC7072);
    check("bp_K2", obs_k[1], 48'h79AED9DBC9E5);
    check("bp_K16", obs_k[15], 48'hCB3D8B0E17F5);

    // Abort at idx 7 together with a handshake
    run_sched(KAT_KEY, 1'b0, 0, 7);
    check("abort_at_idx", bus.subkey_idx, 7);
    bus.subkey_ready = 1'b1;
    bus.abort        = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", bus.subkey_valid, 1'b0);
    check("abort_key_ready", bus.key_ready, 1'b1);
    run_sched({$urandom, $urandom}, 1'b0, 0, -1);

    // All-zero key: even parity in every byte
    run_sched(64'h0, 1'b0, 1, -1);
`ifdef DES_KEY_PARITY_CHK_EN
    check("parity_bad", parity_err, 1'b1);
`endif

    // Reset in the middle of a schedule
    run_sched(KAT_KEY, 1'b0, 0, 9);
    check("reset_at_idx", bus.subkey_idx, 9);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", bus.subkey_valid, 1'b0);
    check("midrst_last", bus.subkey_last, 1'b0);
    check("midrst_idx", bus.subkey_idx, 0);
    check("midrst_key_ready", bus.key_ready, 1'b0);
    check("midrst_subkey", bus.subkey, 0);
`ifdef DES_KEY_PARITY_CHK_EN
    check("midrst_parity", parity_err, 1'b0);
`endif
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_midrst_no_valid", bus.subkey_valid, 1'b0);
    end
`ifdef DES_KEY_PARITY_CHK_EN
    // A clean key clears a previous error
    run_sched(64'h0, 1'b0, 0, -1);
    run_sched(KAT_KEY, 1'b0, 0, -1);
    check("parity_cleared", parity_err, 1'b0);
`endif

    // Random keys, direction and backpressure
    for (int t = 0; t < 6; t++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, number of subkeys generated per key (legal 1..16).
REQ-002 SHALL have parameter IDX_W, default 4, width of subkey_idx (must hold ROUNDS-1).
REQ-003 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: key  input  64  initial key; DES bit 1 = key[63].
REQ-006 SHALL have ports: key_valid  input  1 / key_ready  output  1  key load handshake.
REQ-007 SHALL have ports: decrypt  input  1  sampled with key; 1 = subkeys in order K_ROUNDS..K1.
REQ-008 SHALL have ports: abort  input  1  discard current schedule, return to IDLE.
REQ-009 SHALL have ports: subkey  output  48 / subkey_valid  output  1 / subkey_ready  input  1  subkey stream handshake.
REQ-010 SHALL have ports: subkey_idx  output  IDX_W  round number minus 1 (0 = K1); subkey_last  output  1  final subkey of schedule.

Function
REQ-011 SHALL implement FSM IDLE, RUN: IDLE -> RUN on key_valid&&key_ready; RUN -> IDLE on subkey_last handshake or abort.
REQ-012 SHALL assert key_ready only in IDLE; key transfer occurs on key_valid&&key_ready.
REQ-013 SHALL on key transfer load C,D (28 bits each) from PC1(key); encrypt: C,D = rotl(PC1 halves, SHIFT[1]); decrypt: C,D = rotl(PC1 halves, sum of SHIFT[1..ROUNDS]).
REQ-014 SHALL present subkey = PC2(C,D) combinationally from registered C,D; first subkey_valid the cycle after key transfer.
REQ-015 SHALL on each subkey handshake in RUN: encrypt, rotate C,D left by SHIFT[r+1]; decrypt, rotate C,D right by SHIFT[r]; r = current round 1..ROUNDS.
REQ-016 SHALL use SHIFT = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1} for rounds 1..16.
REQ-017 SHALL hold subkey, subkey_idx, C, D stable while subkey_valid&&!subkey_ready.
REQ-018 SHALL sustain one subkey per cycle with subkey_ready held high.
REQ-019 SHALL count subkey_idx 0..ROUNDS-1 in encrypt and ROUNDS-1..0 in decrypt; subkey_last high on the ROUNDS-th subkey presented.
REQ-020 SHALL give abort priority over a simultaneous subkey handshake: FSM to IDLE, subkey_valid low next cycle, the handshake still counts as accepted.
REQ-021 SHALL ignore abort in IDLE; key_valid during RUN SHALL be held off (key_ready low).
REQ-022 SHALL, for ROUNDS=1, produce exactly one subkey with subkey_last high.

Reset
REQ-023 SHALL on reset low asynchronously force FSM=IDLE, C=D=0, subkey_idx=0, subkey_valid=0, subkey_last=0, key_ready=0 while reset asserted; key_ready=1 first cycle after release.
REQ-024 SHALL, on reset mid-schedule, discard the schedule; no subkey_valid until a new key transfer.

Configuration
REQ-025 SHALL, with DES_KEY_PARITY_CHK_EN defined, add output parity_err (1 bit) registered on key transfer: 1 if any key byte lacks odd parity; cleared by reset and by next clean key; schedule still generated.
REQ-026 SHALL, without DES_KEY_PARITY_CHK_EN, have no parity_err port and no parity logic.

Structure
REQ-027 SHALL place PC1 and PC2 tables, SHIFT table, key/subkey width constants in shared package des_pkg.
REQ-028 SHALL implement PC2 as combinational sub-module des_pc2 (56 in, 48 out), reusable by other DES blocks.

Verification
REQ-029 SHALL test encrypt: key 0x133457799BBCDFF1, decrypt=0, ready=1 -> K1 0x1B02EFFC7072 cycle after load, K2 0x79AED9DBC9E5, K16 0xCB3D8B0E17F5 with subkey_last=1, 16 consecutive cycles.
REQ-030 SHALL test decrypt: same key, decrypt=1 -> first 0xCB3D8B0E17F5 idx 15, last 0x1B02EFFC7072 idx 0 with subkey_last=1.
REQ-031 SHALL test backpressure: ready low 3 cycles on idx 4 -> subkey/idx held; sequence identical to REQ-029.
REQ-032 SHALL test abort at idx 7 with ready=1 -> subkey_valid low next cycle, key_ready high; new key accepted, K1 correct.
REQ-033 SHALL test reset low at idx 9 -> outputs zero immediately; after release no subkey_valid until new key.
REQ-034 SHALL test DES_KEY_PARITY_CHK_EN: key 0x133457799BBCDFF1 -> parity_err=0; key 0x0000000000000000 -> parity_err=1.
